// File: rtl/xbar_pkg.sv
// Shared crossbar port-buffer definitions: packet geometry and the write/read FSM encoding.
package xbar_pkg;

  localparam int unsigned PKT_BEATS = 4;
  localparam int unsigned BEAT_W    = 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRecv = 2'd1,
    StDrop = 2'd2
  } xbar_state_e;

endpackage

// File: rtl/mc_pkt_counter.sv
// Stored-packet occupancy counter (0..2^(AW-2)) with registered req/full flags.
module mc_pkt_counter #(
  parameter int unsigned AW = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic req,
  output logic full
);

  localparam int unsigned CW = AW - 1;
  localparam logic [CW-1:0] MaxCnt = CW'(2 ** (AW - 2));

  logic [CW-1:0] cnt_q, cnt_d;

  // Simultaneous inc/dec cancel; dec at zero and inc at max are ignored.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec) begin
      if (cnt_q != MaxCnt) cnt_d = cnt_q + CW'(1);
    end else if (dec && !inc) begin
      if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      req   <= 1'b0;
      full  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      req   <= (cnt_d != '0);
      full  <= (cnt_d == MaxCnt);
    end
  end

endmodule

// File: rtl/memory_controller_input.sv
// Write side of a crossbar port buffer: stores 4-beat packets into the packet RAM.
// Optional MC_DROP_CNT_EN adds a saturating drop_cnt output.
module memory_controller_input
  import xbar_pkg::*;
#(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid,
  input  logic          sop,
  input  logic [DW-1:0] din,
  input  logic          rd_done,
  output logic          wen,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] wdata,
  output logic          req,
  output logic          full,
`ifdef MC_DROP_CNT_EN
  output logic [7:0]    drop_cnt,
`endif
  output logic          err
);

  localparam int unsigned SW = AW - BEAT_W;

  xbar_state_e       state_q, state_d;
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [BEAT_W-1:0] dcnt_q, dcnt_d;
  logic [AW-1:0]     waddr_d;
  logic [DW-1:0]     wdata_d;
  logic              wen_d, err_d;
  logic              pkt_inc, drop_start;
  logic [SW-1:0]     slot;
  logic [BEAT_W-1:0] beat;

  assign slot = wptr_q[AW-1:BEAT_W];
  assign beat = wptr_q[BEAT_W-1:0];

  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    dcnt_d     = dcnt_q;
    wen_d      = 1'b0;
    waddr_d    = waddr;
    wdata_d    = wdata;
    err_d      = 1'b0;
    pkt_inc    = 1'b0;
    drop_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (valid && sop) begin
          if (full) begin
            state_d    = StDrop;
            dcnt_d     = BEAT_W'(1);
            drop_start = 1'b1;
          end else begin
            wen_d   = 1'b1;
            waddr_d = {slot, BEAT_W'(0)};
            wdata_d = din;
            wptr_d  = {slot, BEAT_W'(1)};
            state_d = StRecv;
          end
        end
      end
      StRecv: begin
        if (!valid) begin
          err_d   = 1'b1;
          wptr_d  = {slot, BEAT_W'(0)};
          state_d = StIdle;
        end else if (sop) begin
          // Restart in the same slot; the aborted beats get overwritten.
          err_d   = 1'b1;
          wen_d   = 1'b1;
          waddr_d = {slot, BEAT_W'(0)};
          wdata_d = din;
          wptr_d  = {slot, BEAT_W'(1)};
        end else begin
          wen_d   = 1'b1;
          waddr_d = wptr_q;
          wdata_d = din;
          if (beat == BEAT_W'(PKT_BEATS - 1)) begin
            wptr_d  = {slot + SW'(1), BEAT_W'(0)};
            pkt_inc = 1'b1;
            state_d = StIdle;
          end else begin
            wptr_d = wptr_q + AW'(1);
          end
        end
      end
      StDrop: begin
        if (!valid) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else if (sop) begin
          err_d = 1'b1;
          if (full) begin
            dcnt_d     = BEAT_W'(1);
            drop_start = 1'b1;
          end else begin
            wen_d   = 1'b1;
            waddr_d = {slot, BEAT_W'(0)};
            wdata_d = din;
            wptr_d  = {slot, BEAT_W'(1)};
            state_d = StRecv;
          end
        end else if (dcnt_q == BEAT_W'(PKT_BEATS - 1)) begin
          state_d = StIdle;
        end else begin
          dcnt_d = dcnt_q + BEAT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      wptr_q  <= '0;
      dcnt_q  <= '0;
      wen     <= 1'b0;
      waddr   <= '0;
      wdata   <= '0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      dcnt_q  <= dcnt_d;
      wen     <= wen_d;
      waddr   <= waddr_d;
      wdata   <= wdata_d;
      err     <= err_d;
    end
  end

  mc_pkt_counter #(
    .AW(AW)
  ) u_pkt_counter (
    .clk  (clk),
    .rst  (rst),
    .inc  (pkt_inc),
    .dec  (rd_done),
    .req  (req),
    .full (full)
  );

`ifdef MC_DROP_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop_start && drop_cnt != 8'hFF) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`else
  logic unused_drop_start;
  assign unused_drop_start = drop_start;
`endif

endmodule

// File: tb/tb_memory_controller_input.sv
// Directed bench for memory_controller_input with a write scoreboard (MC_DROP_CNT_EN optional).
module tb_memory_controller_input;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 10;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst, valid, sop, rd_done;
  logic [DW-1:0] din;
  logic          wen, req, full, err;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
`ifdef MC_DROP_CNT_EN
  logic [7:0]    drop_cnt;
`endif

  int  vectors     = 0;
  int  miscompares = 0;
  wr_t sb[$];
  wr_t mon_w;

  always #5 clk = ~clk;

  memory_controller_input #(
    .DW(DW),
    .AW(AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .valid    (valid),
    .sop      (sop),
    .din      (din),
    .rd_done  (rd_done),
    .wen      (wen),
    .waddr    (waddr),
    .wdata    (wdata),
    .req      (req),
    .full     (full),
`ifdef MC_DROP_CNT_EN
    .drop_cnt (drop_cnt),
`endif
    .err      (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every RAM write must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && wen) begin
      if (sb.size() == 0) begin
        check("unexpected_wen", 32'(waddr), 32'hFFFF_FFFF);
      end else begin
        mon_w = sb.pop_front();
        check("waddr", 32'(waddr), 32'(mon_w.addr));
        check("wdata", 32'(wdata), 32'(mon_w.data));
      end
    end
  end

  task automatic push(input int addr, input logic [DW-1:0] data);
    wr_t w;
    w.addr = AW'(addr);
    w.data = data;
    sb.push_back(w);
  endtask

  // Drive one beat, then return just after the edge that captured it.
  task automatic cyc(input logic v, input logic s, input logic [DW-1:0] d, input logic rd);
    valid   = v;
    sop     = s;
    din     = d;
    rd_done = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic pkt(input int base, input logic [DW-1:0] d0);
    for (int b = 0; b < 4; b++) begin
      push(base + b, d0 + DW'(b));
      cyc(1'b1, (b == 0), d0 + DW'(b), 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; sop = 1'b0; din = '0; rd_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wen", 32'(wen), 0);
    check("rst_waddr", 32'(waddr), 0);
    check("rst_wdata", 32'(wdata), 0);
    check("rst_req", 32'(req), 0);
    check("rst_full", 32'(full), 0);
    check("rst_err", 32'(err), 0);
    rst = 1'b0;

    // Stray beat without sop must be ignored.
    cyc(1'b1, 1'b0, 8'h55, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);

    // Clean packet into slot 0.
    push(0, 8'hA0); push(1, 8'hA1); push(2, 8'hA2);
    cyc(1'b1, 1'b1, 8'hA0, 1'b0);
    cyc(1'b1, 1'b0, 8'hA1, 1'b0);
    cyc(1'b1, 1'b0, 8'hA2, 1'b0);
    check("req_before_last", 32'(req), 0);
    push(3, 8'hA3);
    cyc(1'b1, 1'b0, 8'hA3, 1'b0);
    check("req_after_pkt", 32'(req), 1);
    check("full_after_pkt", 32'(full), 0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);

    // Drain, then a second rd_done must not underflow.
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    check("req_after_rd", 32'(req), 0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    check("req_no_underflow", 32'(req), 0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    check("req_idle", 32'(req), 0);

    // Valid drops after beat 1: abort, slot 1 reused.
    push(4, 8'hB0); push(5, 8'hB1);
    cyc(1'b1, 1'b1, 8'hB0, 1'b0);
    cyc(1'b1, 1'b0, 8'hB1, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    check("err_gap", 32'(err), 1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    check("err_gap_pulse", 32'(err), 0);
    check("req_after_abort", 32'(req), 0);
    pkt(4, 8'hC0);
    check("req_after_c", 32'(req), 1);

    // sop at beat 2: abort and restart at slot 2 base.
    push(8, 8'hD0); push(9, 8'hD1);
    cyc(1'b1, 1'b1, 8'hD0, 1'b0);
    cyc(1'b1, 1'b0, 8'hD1, 1'b0);
    push(8, 8'hE0);
    cyc(1'b1, 1'b1, 8'hE0, 1'b0);
    check("err_sop", 32'(err), 1);
    push(9, 8'hE1);
    cyc(1'b1, 1'b0, 8'hE1, 1'b0);
    check("err_sop_pulse", 32'(err), 0);
    push(10, 8'hE2); push(11, 8'hE3);
    cyc(1'b1, 1'b0, 8'hE2, 1'b0);
    cyc(1'b1, 1'b0, 8'hE3, 1'b0);
    check("err_restart_clean", 32'(err), 0);

    // Count 2 -> 1, then completion and rd_done in the same cycle keep it at 1.
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    check("req_cnt1", 32'(req), 1);
    push(12, 8'hF0); push(13, 8'hF1); push(14, 8'hF2); push(15, 8'hF3);
    cyc(1'b1, 1'b1, 8'hF0, 1'b0);
    cyc(1'b1, 1'b0, 8'hF1, 1'b0);
    cyc(1'b1, 1'b0, 8'hF2, 1'b0);
    cyc(1'b1, 1'b0, 8'hF3, 1'b1);
    check("req_inc_dec", 32'(req), 1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    check("req_cnt0", 32'(req), 0);

    // Fill all 256 slots starting at slot 4, wrapping past address 1023.
    for (int i = 0; i < 256; i++) begin
      pkt(((4 + i) % 256) * 4, DW'(i));
      if (i == 254) check("full_at_255", 32'(full), 0);
    end
    check("full_at_256", 32'(full), 1);
    check("req_at_256", 32'(req), 1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);

    // Packet 257 is swallowed with no write.
    cyc(1'b1, 1'b1, 8'h77, 1'b0);
    cyc(1'b1, 1'b0, 8'h78, 1'b0);
    cyc(1'b1, 1'b0, 8'h79, 1'b0);
    cyc(1'b1, 1'b0, 8'h7A, 1'b0);
    check("drop_no_err", 32'(err), 0);
    check("full_after_drop", 32'(full), 1);
`ifdef MC_DROP_CNT_EN
    check("drop_cnt_1", 32'(drop_cnt), 1);
`endif
    cyc(1'b0, 1'b0, 8'h00, 1'b0);

    // Dropped packet cut short also flags err.
    cyc(1'b1, 1'b1, 8'h88, 1'b0);
    cyc(1'b1, 1'b0, 8'h89, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    check("err_drop_gap", 32'(err), 1);
`ifdef MC_DROP_CNT_EN
    check("drop_cnt_2", 32'(drop_cnt), 2);
`endif

    // Free one slot; next packet lands at slot 4 since drops never moved wptr.
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    check("full_after_rd", 32'(full), 0);
    check("req_after_rd_full", 32'(req), 1);
    pkt(16, 8'hC8);
    check("full_refill", 32'(full), 1);

    repeat (3) cyc(1'b0, 1'b0, 8'h00, 1'b0);
    check("sb_empty", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
